bios_boot_loader: RTL and testbench
===================================

# bios_boot_loader

- Copies the 16 hardcoded BIOS instruction words into the i281 code memory after reset.
- Holds the CPU stalled until the copy completes.
- Sits between the BIOS ROM outputs and the code-memory write port, and drives the CPU's hold input.
- Optionally reads every word back and compares it against the ROM before releasing the CPU.

## Interface
Parameters:
- ADDR_W, 6, code-memory address width.
- BASE_ADDR, 0, code-memory address of BIOS word 0; must satisfy BASE_ADDR + 15 < 2^ADDR_W.

Ports:
- Clock  input  1  single system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- b0 … b15  input  16 each  BIOS words, static during operation.
- start  input  1  one-cycle pulse that re-runs the load from DONE or ERR; ignored elsewhere.
- cm_ready  input  1  code memory accepts the current write/read request this cycle.
- cm_wr_en  output  1  write request.
- cm_addr  output  ADDR_W  write/read address.
- cm_wr_data  output  16  write data.
- cm_rd_en  output  1  read request (verify only).
- cm_rd_data  input  16  read data, valid exactly one cycle after an accepted read.
- cpu_hold  output  1  high while the CPU must not fetch.
- boot_done  output  1  load (and verify) completed successfully.
- boot_error  output  1  verify mismatch latched.
- err_index  output  4  BIOS index of the first mismatch.

## Operation
- Reset values: cm_wr_en=0, cm_rd_en=0, cm_addr=BASE_ADDR, cm_wr_data=0, cpu_hold=1, boot_done=0, boot_error=0, err_index=0.
- All outputs are registered. Internal 4-bit index idx resets to 0.
- State machine:
  - WRITE:
    - Entered on the first clock after Resetn deasserts.
    - Drives cm_wr_en=1, cm_addr=BASE_ADDR+idx, cm_wr_data=b[idx].
    - On accept (cm_wr_en & cm_ready): idx+1.
    - Accept at idx=15: go to VERIFY, or to DONE when verify is compiled out; idx returns to 0.
  - VERIFY_RD:
    - Drives cm_rd_en=1, cm_addr=BASE_ADDR+idx.
    - On accept: go to VERIFY_CMP.
  - VERIFY_CMP:
    - Captures cm_rd_data and compares it to b[idx].
    - Mismatch: go to ERR, with err_index=idx and boot_error=1.
    - Match at idx=15: go to DONE.
    - Otherwise: idx+1 and go back to VERIFY_RD.
  - DONE: cpu_hold=0, boot_done=1.
  - ERR: cpu_hold=1, boot_error=1, boot_done=0.
- start pulse in DONE or ERR: clears boot_done, boot_error and err_index, sets cpu_hold=1, idx=0, and goes to WRITE.
- cm_ready low holds the request, with address and data stable, until accepted. There is no timeout.
- Address arithmetic is ADDR_W bits wide and idx never wraps mid-load: 15 is the terminal index.
- Resetn low at any time, mid-load included: immediate return to reset values. The load restarts from index 0 after release.
- b0..b15 are sampled combinationally at issue time. Changing them mid-load is undefined.

## Timing
- With cm_ready tied high:
  - Verify compiled out: one word is written per cycle. The first write is visible in the first cycle after reset release, and boot_done rises 17 cycles after reset release.
  - Verify compiled in: 16 writes plus 16×2 read/compare cycles; boot_done rises 49 cycles after reset release.
- cpu_hold falls in the same cycle boot_done rises.
- cm_wr_en and cm_rd_en are never high together.
- start is a don't-care in WRITE and VERIFY. start coincident with DONE entry is ignored.

## Configuration
- Macro BIOS_BOOT_VERIFY_EN, which controls the read-back verify.
- Defined:
  - VERIFY_RD and VERIFY_CMP exist.
  - cm_rd_en, boot_error and err_index are live.
- Undefined:
  - WRITE goes directly to DONE after idx=15.
  - cm_rd_en, boot_error and err_index are tied 0.
  - cm_rd_data is unused.

## Test plan
- Reset release, cm_ready=1, verify off, with the standard BIOS words (b0=16'h5C10, b15=16'h0000):
  - cm_addr steps 0..15 on consecutive cycles with matching data.
  - boot_done=1 and cpu_hold=0 at cycle 17.
- Reset release, cm_ready toggling every other cycle:
  - Each word is held stable until accepted.
  - Exactly 16 writes occur.
  - Address and data ordering are preserved.
- BASE_ADDR=48: writes land at 48..63, and no address above 63 is produced.
- Verify on, with a memory model that returns the written data: boot_done rises at cycle 49 and boot_error stays 0.
- Verify on, with the model corrupting word 6 (returns 16'h0000 instead of 16'hC0FA):
  - boot_error=1, err_index=6, cpu_hold=1.
  - A start pulse reloads and, with the model fixed, reaches DONE.
- Resetn asserted during the write at idx=9: all outputs return to reset values immediately, and after release writing restarts at BASE_ADDR with b0.

Source files
------------

// File: rtl/bios_boot_loader.sv
// Copies the 16 BIOS words into i281 code memory after reset and holds the CPU until done.
// Optional read-back verify is enabled by defining BIOS_BOOT_VERIFY_EN.
module bios_boot_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       b0,
    input  logic [15:0]       b1,
    input  logic [15:0]       b2,
    input  logic [15:0]       b3,
    input  logic [15:0]       b4,
    input  logic [15:0]       b5,
    input  logic [15:0]       b6,
    input  logic [15:0]       b7,
    input  logic [15:0]       b8,
    input  logic [15:0]       b9,
    input  logic [15:0]       b10,
    input  logic [15:0]       b11,
    input  logic [15:0]       b12,
    input  logic [15:0]       b13,
    input  logic [15:0]       b14,
    input  logic [15:0]       b15,
    input  logic              start,
    input  logic              cm_ready,
    output logic              cm_wr_en,
    output logic [ADDR_W-1:0] cm_addr,
    output logic [15:0]       cm_wr_data,
    output logic              cm_rd_en,
    input  logic [15:0]       cm_rd_data,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              boot_error,
    output logic [3:0]        err_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY_RD,
        S_VERIFY_CMP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [15:0] bios [16];

    assign idx_next = idx + 4'd1;

    assign bios[0]  = b0;
    assign bios[1]  = b1;
    assign bios[2]  = b2;
    assign bios[3]  = b3;
    assign bios[4]  = b4;
    assign bios[5]  = b5;
    assign bios[6]  = b6;
    assign bios[7]  = b7;
    assign bios[8]  = b8;
    assign bios[9]  = b9;
    assign bios[10] = b10;
    assign bios[11] = b11;
    assign bios[12] = b12;
    assign bios[13] = b13;
    assign bios[14] = b14;
    assign bios[15] = b15;

`ifndef BIOS_BOOT_VERIFY_EN
    logic unused_rd;
    assign unused_rd  = ^cm_rd_data;
    assign cm_rd_en   = 1'b0;
    assign boot_error = 1'b0;
    assign err_index  = 4'd0;
`endif

    // Outputs are computed one state ahead so each request is registered the cycle it is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            cm_wr_en   <= 1'b0;
            cm_addr    <= BASE;
            cm_wr_data <= 16'h0000;
            cpu_hold   <= 1'b1;
            boot_done  <= 1'b0;
`ifdef BIOS_BOOT_VERIFY_EN
            cm_rd_en   <= 1'b0;
            boot_error <= 1'b0;
            err_index  <= 4'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_WRITE;
                    idx        <= 4'd0;
                    cm_wr_en   <= 1'b1;
                    cm_addr    <= BASE;
                    cm_wr_data <= bios[0];
                end
                S_WRITE: begin
                    if (cm_ready) begin
                        if (idx == 4'd15) begin
                            cm_wr_en <= 1'b0;
                            idx      <= 4'd0;
`ifdef BIOS_BOOT_VERIFY_EN
                            state    <= S_VERIFY_RD;
                            cm_rd_en <= 1'b1;
                            cm_addr  <= BASE;
`else
                            state     <= S_DONE;
                            cpu_hold  <= 1'b0;
                            boot_done <= 1'b1;
`endif
                        end else begin
                            idx        <= idx_next;
                            cm_addr    <= BASE + ADDR_W'(idx_next);
                            cm_wr_data <= bios[idx_next];
                        end
                    end
                end
`ifdef BIOS_BOOT_VERIFY_EN
                S_VERIFY_RD: begin
                    if (cm_ready) begin
                        cm_rd_en <= 1'b0;
                        state    <= S_VERIFY_CMP;
                    end
                end
                // Read data is valid exactly in this cycle, one after the read was accepted.
                S_VERIFY_CMP: begin
                    if (cm_rd_data != bios[idx]) begin
                        state      <= S_ERR;
                        boot_error <= 1'b1;
                        err_index  <= idx;
                    end else if (idx == 4'd15) begin
                        state     <= S_DONE;
                        cpu_hold  <= 1'b0;
                        boot_done <= 1'b1;
                    end else begin
                        idx      <= idx_next;
                        cm_rd_en <= 1'b1;
                        cm_addr  <= BASE + ADDR_W'(idx_next);
                        state    <= S_VERIFY_RD;
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_WRITE;
                        idx        <= 4'd0;
                        cm_wr_en   <= 1'b1;
                        cm_addr    <= BASE;
                        cm_wr_data <= bios[0];
                        cpu_hold   <= 1'b1;
                        boot_done  <= 1'b0;
`ifdef BIOS_BOOT_VERIFY_EN
                        boot_error <= 1'b0;
                        err_index  <= 4'd0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bios_boot_loader.sv
// Scoreboard bench for bios_boot_loader at BASE_ADDR=48; covers both BIOS_BOOT_VERIFY_EN builds.
module tb_bios_boot_loader;

    localparam int ADDR_W = 6;
    localparam int BASE   = 48;
`ifdef BIOS_BOOT_VERIFY_EN
    localparam int DONE_CYC = 49;
`else
    localparam int DONE_CYC = 17;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       bw [16];
    logic              start;
    logic              cm_ready;
    logic              cm_wr_en;
    logic [ADDR_W-1:0] cm_addr;
    logic [15:0]       cm_wr_data;
    logic              cm_rd_en;
    logic [15:0]       cm_rd_data;
    logic              cpu_hold;
    logic              boot_done;
    logic              boot_error;
    logic [3:0]        err_index;

    wr_t         expQ [$];
    logic [15:0] mem [64];
    int          checks = 0;
    int          passes = 0;
    int          writesSeen = 0;
    int          readyMode = 0;
    bit          corruptOn = 1'b0;

    always #5 clk = ~clk;

    bios_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .b0(bw[0]), .b1(bw[1]), .b2(bw[2]), .b3(bw[3]),
        .b4(bw[4]), .b5(bw[5]), .b6(bw[6]), .b7(bw[7]),
        .b8(bw[8]), .b9(bw[9]), .b10(bw[10]), .b11(bw[11]),
        .b12(bw[12]), .b13(bw[13]), .b14(bw[14]), .b15(bw[15]),
        .start(start), .cm_ready(cm_ready),
        .cm_wr_en(cm_wr_en), .cm_addr(cm_addr), .cm_wr_data(cm_wr_data),
        .cm_rd_en(cm_rd_en), .cm_rd_data(cm_rd_data),
        .cpu_hold(cpu_hold), .boot_done(boot_done),
        .boot_error(boot_error), .err_index(err_index)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    // Reference: a load is simply the 16 BIOS words written in order at BASE..BASE+15.
    task automatic applyStimulus();
        expQ.delete();
        writesSeen = 0;
        for (int i = 0; i < 16; i++) expQ.push_back(wr_t'{addr: ADDR_W'(BASE + i), data: bw[i]});
    endtask

    task automatic randomizeBios();
        for (int i = 0; i < 16; i++) bw[i] = 16'($urandom);
        bw[0]  = 16'h5C10;
        bw[6]  = 16'hC0FA;
        bw[15] = 16'h0000;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(cm_wr_en), 32'd0);
        checkOutput({tag, "_rd_en"}, 32'(cm_rd_en), 32'd0);
        checkOutput({tag, "_addr"}, 32'(cm_addr), 32'(BASE));
        checkOutput({tag, "_wr_data"}, 32'(cm_wr_data), 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_boot_done"}, 32'(boot_done), 32'd0);
        checkOutput({tag, "_boot_error"}, 32'(boot_error), 32'd0);
        checkOutput({tag, "_err_index"}, 32'(err_index), 32'd0);
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 500; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc = i;
            if (boot_done || boot_error) return;
        end
        checkOutput("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Handshake driver: ready always high, toggling, or random.
    initial begin
        cm_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       cm_ready = 1'b1;
                1:       cm_ready = ~cm_ready;
                default: cm_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Memory read port: data appears one cycle after an accepted read.
    initial begin
        logic [ADDR_W-1:0] a;
        cm_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst_n && cm_rd_en && cm_ready) begin
                a = cm_addr;
                @(posedge clk);
                #1;
                cm_rd_data = (corruptOn && a == ADDR_W'(BASE + 6)) ? 16'h0000 : mem[a];
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write and checks request stability.
    initial begin
        wr_t exp;
        bit  pend = 1'b0;
        wr_t held;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (cm_wr_en && cm_rd_en) checkOutput("wr_rd_overlap", 32'd1, 32'd0);
                if (pend && cm_wr_en) begin
                    checkOutput("held_addr", 32'(cm_addr), 32'(held.addr));
                    checkOutput("held_data", 32'(cm_wr_data), 32'(held.data));
                end
                pend = cm_wr_en && !cm_ready;
                held = wr_t'{addr: cm_addr, data: cm_wr_data};
                if (cm_wr_en && cm_ready) begin
                    writesSeen++;
                    mem[cm_addr] = cm_wr_data;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_write", 32'(cm_addr), 32'hFFFF_FFFF);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("write_addr", 32'(cm_addr), 32'(exp.addr));
                        checkOutput("write_data", 32'(cm_wr_data), 32'(exp.data));
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        randomizeBios();
        #3;
        @(negedge clk);
        checkReset("reset");

        // Full-speed load straight out of reset.
        applyStimulus();
        rst_n = 1'b1;
        waitDone(cyc);
        checkOutput("done_cycle", 32'(cyc), 32'(DONE_CYC));
        checkOutput("done_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("done_error", 32'(boot_error), 32'd0);
        checkOutput("write_count", 32'(writesSeen), 32'd16);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        // Reload with toggling ready and fresh words.
        randomizeBios();
        readyMode = 1;
        applyStimulus();
        pulseStart();
        waitDone(cyc);
        checkOutput("toggle_done", 32'(boot_done), 32'd1);
        checkOutput("toggle_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("toggle_write_count", 32'(writesSeen), 32'd16);
        checkOutput("toggle_queue_empty", 32'(expQ.size()), 32'd0);

`ifdef BIOS_BOOT_VERIFY_EN
        // Corrupted read-back of word 6, then a clean retry.
        randomizeBios();
        readyMode = 2;
        corruptOn = 1'b1;
        applyStimulus();
        pulseStart();
        waitDone(cyc);
        checkOutput("err_flag", 32'(boot_error), 32'd1);
        checkOutput("err_index", 32'(err_index), 32'd6);
        checkOutput("err_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("err_done", 32'(boot_done), 32'd0);
        corruptOn = 1'b0;
        applyStimulus();
        pulseStart();
        waitDone(cyc);
        checkOutput("retry_done", 32'(boot_done), 32'd1);
        checkOutput("retry_error", 32'(boot_error), 32'd0);
        checkOutput("retry_err_index", 32'(err_index), 32'd0);
`endif

        // Reset in the middle of the write at index 9.
        readyMode = 0;
        randomizeBios();
        applyStimulus();
        pulseStart();
        guard = 0;
        while (!(cm_wr_en && cm_addr == ADDR_W'(BASE + 9)) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_idx9", 32'(guard < 100), 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        repeat (3) @(negedge clk);
        applyStimulus();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("restart_wr_en", 32'(cm_wr_en), 32'd1);
        checkOutput("restart_addr", 32'(cm_addr), 32'(BASE));
        checkOutput("restart_data", 32'(cm_wr_data), 32'(bw[0]));
        waitDone(cyc);
        checkOutput("restart_done_cycle", 32'(cyc + 1), 32'(DONE_CYC));
        checkOutput("restart_write_count", 32'(writesSeen), 32'd16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
